// File: rtl/i2c_target_regfile_if.sv
// I2C pin bundle between a bus master (or bench) and the register-file target.
// SDA is open drain: the target only ever requests a low level through sda_oe_o.
interface i2c_target_regfile_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe_o;

    modport master (output scl_i, output sda_i, input sda_oe_o);
    modport slave  (input scl_i, input sda_i, output sda_oe_o);
endinterface

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file, standing in for the ADV7511 control port.
// Committed writes are reported on a one-cycle strobe; a registered side port exposes the file.
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR    = 7'h39,
    parameter int         REG_AW      = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    i2c_target_regfile_if.slave bus,
    output logic                wr_valid_o,
    output logic [REG_AW-1:0]   wr_addr_o,
    output logic [7:0]          wr_data_o,
    output logic                busy_o,
    input  logic [REG_AW-1:0]   dbg_addr_i,
    output logic [7:0]          dbg_data_o
);
    localparam int DEPTH = 1 << REG_AW;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RACK, ST_IGNORE
    } state_t;

    state_t state_q, state_next;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_d, sda_d, scl_s, sda_s;
    logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;

    logic [2:0]        bit_cnt_q;
    logic [6:0]        shift_q;
    logic [7:0]        shift_in;
    logic [6:0]        tx_q;
    logic [REG_AW-1:0] ptr_q;
    logic              rw_q, ack_phase_q;
    logic              sda_oe_q, oe_next, wr_fire, busy_q;
    logic [7:0]        rf_rd;
    logic [7:0]        regfile [DEPTH];

    // Synchronizers reset high so an idle bus produces no edges when reset releases.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign sda_rise  = sda_s & ~sda_d;
    assign sda_fall  = ~sda_s & sda_d;
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;
    assign shift_in  = {shift_q, sda_s};
    assign rf_rd     = regfile[ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        if (start_det) begin
            state_next = ST_ADDR;
        end else if (stop_det) begin
            state_next = ST_IDLE;
        end else begin
            case (state_q)
                ST_ADDR:
                    if (scl_rise && bit_cnt_q == 3'd7)
                        state_next = (shift_in[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK:
                    if (scl_fall && ack_phase_q) state_next = rw_q ? ST_RDATA : ST_REG;
                ST_REG:
                    if (scl_rise && bit_cnt_q == 3'd7) state_next = ST_REG_ACK;
                ST_REG_ACK:
                    if (scl_fall && ack_phase_q) state_next = ST_WDATA;
                ST_WDATA:
                    if (scl_rise && bit_cnt_q == 3'd7) state_next = ST_WDATA_ACK;
                ST_WDATA_ACK:
                    if (scl_fall && ack_phase_q) state_next = ST_WDATA;
                ST_RDATA:
                    if (scl_fall && bit_cnt_q == 3'd7) state_next = ST_RACK;
                ST_RACK:
                    if (scl_rise && sda_s)               state_next = ST_IGNORE;
                    else if (scl_fall && ack_phase_q)    state_next = ST_RDATA;
                default: state_next = state_q;
            endcase
        end
    end

    // Entering RDATA must put the MSB on the wire at the same SCL fall that ends the ACK slot.
    always_comb begin
        oe_next = 1'b0;
        wr_fire = 1'b0;
        if (!(start_det || stop_det)) begin
            case (state_q)
                ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                    oe_next = sda_oe_q;
                    if (scl_fall) begin
                        if (!ack_phase_q)                          oe_next = 1'b1;
                        else if (state_q == ST_ADDR_ACK && rw_q)   oe_next = ~rf_rd[7];
                        else                                       oe_next = 1'b0;
                    end
                end
                ST_RDATA: begin
                    oe_next = sda_oe_q;
                    if (scl_fall) oe_next = (bit_cnt_q == 3'd7) ? 1'b0 : ~tx_q[6];
                end
                ST_RACK:  oe_next = scl_fall && ack_phase_q && !rf_rd[7];
                ST_WDATA: wr_fire = scl_rise && bit_cnt_q == 3'd7;
                default:  oe_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            ack_phase_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sda_oe_q <= oe_next;
            if (start_det)     busy_q <= 1'b1;
            else if (stop_det) busy_q <= 1'b0;

            if (start_det || stop_det) begin
                bit_cnt_q   <= '0;
                ack_phase_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR, ST_REG, ST_WDATA:
                        if (scl_rise) begin
                            shift_q   <= shift_in[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (state_q == ST_ADDR)  rw_q  <= sda_s;
                                if (state_q == ST_REG)   ptr_q <= shift_in[REG_AW-1:0];
                                if (state_q == ST_WDATA) ptr_q <= ptr_q + REG_AW'(1);
                            end
                        end
                    ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK:
                        if (scl_fall) begin
                            ack_phase_q <= ~ack_phase_q;
                            if (ack_phase_q) begin
                                tx_q      <= rf_rd[6:0];
                                bit_cnt_q <= '0;
                            end
                        end
                    ST_RDATA:
                        if (scl_fall) begin
                            if (bit_cnt_q == 3'd7) begin
                                bit_cnt_q <= '0;
                                ptr_q     <= ptr_q + REG_AW'(1);
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                tx_q      <= {tx_q[5:0], 1'b0};
                            end
                        end
                    ST_RACK:
                        if (scl_rise) begin
                            ack_phase_q <= ~sda_s;
                        end else if (scl_fall && ack_phase_q) begin
                            ack_phase_q <= 1'b0;
                            tx_q        <= rf_rd[6:0];
                        end
                    default: ;
                endcase
            end
        end
    end

    // Side read port samples before this cycle's write lands, so it shows the old byte first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) regfile[i] <= 8'h00;
            wr_valid_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= 8'h00;
            dbg_data_o <= 8'h00;
        end else begin
            wr_valid_o <= wr_fire;
            dbg_data_o <= regfile[dbg_addr_i];
            if (wr_fire) begin
                regfile[ptr_q] <= shift_in;
                wr_addr_o      <= ptr_q;
                wr_data_o      <= shift_in;
            end
        end
    end

    assign bus.sda_oe_o = sda_oe_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, open-drain SDA, and a byte-array
// model of the register file and pointer used to predict writes, reads and readbacks.
`timescale 1ns/1ps
module tb_i2c_target_regfile;
    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       wr_valid, busy;
    logic [7:0] wr_addr, wr_data, dbg_addr, dbg_data;

    i2c_target_regfile_if bus();
    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe_o;

    i2c_target_regfile #(.DEV_ADDR(7'h39), .REG_AW(8), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .busy_o(busy), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    int checks, failures;

    // Observed write strobes and SDA pull-down activity, sampled on the falling clock edge.
    int         wr_cnt, oe_cnt, wr_long;
    bit         wr_prev;
    logic [7:0] log_addr [256];
    logic [7:0] log_data [256];
    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            if (wr_cnt < 256) begin
                log_addr[wr_cnt] = wr_addr;
                log_data[wr_cnt] = wr_data;
            end
            wr_cnt++;
            if (wr_prev) wr_long++;
        end
        wr_prev = (wr_valid === 1'b1);
        if (bus.sda_oe_o === 1'b1) oe_cnt++;
    end

    logic [7:0] m_rf [256];
    logic [7:0] m_ptr;
    logic [7:0] exp_addr [256];
    logic [7:0] exp_data [256];
    int         exp_cnt;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        b = bus.sda_i; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        acked = (b === 1'b0);
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~master_ack);
    endtask

    // Address byte, register pointer, n data bytes; the model follows only traffic addressed to 0x72.
    task automatic write_txn(input logic [7:0] dev, input logic [7:0] regp, input logic [7:0] d0,
                             input logic [7:0] d1, input int n, input bit do_stop,
                             output int acks, output logic busy_mid);
        logic       a;
        logic [7:0] d;
        acks = 0;
        i2c_start();
        send_byte(dev, a); busy_mid = busy; acks += int'(a);
        send_byte(regp, a); acks += int'(a);
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? d0 : d1;
            send_byte(d, a);
            acks += int'(a);
        end
        if (do_stop) i2c_stop();
        if (dev == 8'h72) begin
            m_ptr = regp;
            for (int i = 0; i < n; i++) begin
                d = (i == 0) ? d0 : d1;
                m_rf[m_ptr] = d;
                exp_addr[exp_cnt] = m_ptr;
                exp_data[exp_cnt] = d;
                exp_cnt++;
                m_ptr = m_ptr + 8'd1;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) m_rf[i] = 8'h00;
        m_ptr = 8'h00;
        dbg_addr = 8'($urandom);
        rst = 1'b1;
        wait_clk(4);
        checks++; if (bus.sda_oe_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_sda_oe: got %b expected 0", bus.sda_oe_o); end
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_valid: got %b expected 0", wr_valid); end
        checks++; if (wr_addr !== 8'h00) begin failures++; $display("[TB] FAIL reset_wr_addr: got %h expected 00", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_wr_data: got %h expected 00", wr_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (dbg_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_dbg: got %h expected 00", dbg_data); end
        rst = 1'b0;
        wait_clk(4);
        checks++; if (dbg_data !== m_rf[dbg_addr]) begin failures++; $display("[TB] FAIL reset_dbg_after: got %h expected %h", dbg_data, m_rf[dbg_addr]); end
    endtask

    task automatic test_basic_write();
        int   acks, base;
        logic bm;
        base = wr_cnt;
        write_txn(8'h72, 8'h41, 8'h10, 8'h00, 1, 1'b1, acks, bm);
        checks++; if (acks !== 3) begin failures++; $display("[TB] FAIL basic_acks: got %0d expected 3", acks); end
        checks++; if (wr_cnt - base !== 1) begin failures++; $display("[TB] FAIL basic_pulses: got %0d expected 1", wr_cnt - base); end
        checks++; if ({log_addr[base], log_data[base]} !== {8'h41, 8'h10}) begin failures++; $display("[TB] FAIL basic_write: got %h/%h expected 41/10", log_addr[base], log_data[base]); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_after_stop: got %b expected 0", busy); end
        dbg_addr = 8'h41; wait_clk(2);
        checks++; if (dbg_data !== m_rf[8'h41]) begin failures++; $display("[TB] FAIL basic_dbg: got %h expected %h", dbg_data, m_rf[8'h41]); end
    endtask

    task automatic test_wrong_addr();
        int         acks, wbase, obase;
        logic       bm;
        logic [7:0] dev;
        for (int it = 0; it < 2; it++) begin
            if (it == 0) dev = 8'h74;
            else do dev = 8'($urandom); while (dev[7:1] == 7'h39);
            wbase = wr_cnt; obase = oe_cnt;
            write_txn(dev, 8'($urandom), 8'($urandom), 8'h00, 1, 1'b1, acks, bm);
            checks++; if (acks !== 0) begin failures++; $display("[TB] FAIL wrong_addr_acks: dev %h got %0d expected 0", dev, acks); end
            checks++; if (oe_cnt !== obase) begin failures++; $display("[TB] FAIL wrong_addr_sda: got %0d low cycles expected 0", oe_cnt - obase); end
            checks++; if (wr_cnt !== wbase) begin failures++; $display("[TB] FAIL wrong_addr_pulses: got %0d expected 0", wr_cnt - wbase); end
            checks++; if (bm !== 1'b1) begin failures++; $display("[TB] FAIL wrong_addr_busy: got %b expected 1", bm); end
        end
    endtask

    task automatic test_burst_wrap();
        int   acks, base;
        logic bm;
        base = wr_cnt;
        write_txn(8'h72, 8'hFF, 8'hAA, 8'hBB, 2, 1'b1, acks, bm);
        checks++; if (acks !== 4) begin failures++; $display("[TB] FAIL burst_acks: got %0d expected 4", acks); end
        checks++; if (wr_cnt - base !== 2) begin failures++; $display("[TB] FAIL burst_pulses: got %0d expected 2", wr_cnt - base); end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({log_addr[base+k], log_data[base+k]} !== {exp_addr[exp_cnt-2+k], exp_data[exp_cnt-2+k]}) begin
                failures++;
                $display("[TB] FAIL burst_write%0d: got %h/%h expected %h/%h", k, log_addr[base+k], log_data[base+k], exp_addr[exp_cnt-2+k], exp_data[exp_cnt-2+k]);
            end
        end
        dbg_addr = 8'hFF; wait_clk(2);
        checks++; if (dbg_data !== 8'hAA) begin failures++; $display("[TB] FAIL burst_dbg_ff: got %h expected aa", dbg_data); end
        dbg_addr = 8'h00; wait_clk(2);
        checks++; if (dbg_data !== 8'hBB) begin failures++; $display("[TB] FAIL burst_dbg_00: got %h expected bb", dbg_data); end
    endtask

    task automatic test_read();
        int         acks, n, obase, wbase;
        logic       bm, a;
        logic [7:0] p, got, want;
        write_txn(8'h72, 8'h42, 8'($urandom_range(1, 255)), 8'h00, 1, 1'b1, acks, bm);
        for (int it = 0; it < 2; it++) begin
            p = (it == 0) ? 8'h41 : 8'($urandom);
            n = (it == 0) ? 2 : int'($urandom_range(1, 4));
            wbase = wr_cnt;
            write_txn(8'h72, p, 8'h00, 8'h00, 0, 1'b0, acks, bm);
            i2c_start();
            send_byte(8'h73, a);
            checks++; if (acks + int'(a) !== 3) begin failures++; $display("[TB] FAIL read_acks: got %0d expected 3", acks + int'(a)); end
            for (int k = 0; k < n; k++) begin
                want = m_rf[m_ptr];
                recv_byte(k != n - 1, got);
                m_ptr = m_ptr + 8'd1;
                checks++; if (got !== want) begin failures++; $display("[TB] FAIL read_byte%0d: ptr %h got %h expected %h", k, m_ptr - 8'd1, got, want); end
            end
            obase = oe_cnt;
            checks++; if (bus.sda_oe_o !== 1'b0) begin failures++; $display("[TB] FAIL read_release: got %b expected 0", bus.sda_oe_o); end
            i2c_stop();
            checks++; if (oe_cnt !== obase) begin failures++; $display("[TB] FAIL read_after_nack: got %0d low cycles expected 0", oe_cnt - obase); end
            checks++; if (wr_cnt !== wbase) begin failures++; $display("[TB] FAIL read_pulses: got %0d expected 0", wr_cnt - wbase); end
        end
    endtask

    task automatic test_partial_stop();
        int         acks, base;
        logic       bm, a;
        logic [7:0] p, d, got;
        p = 8'($urandom); d = 8'($urandom);
        base = wr_cnt;
        write_txn(8'h72, p, 8'h00, 8'h00, 0, 1'b0, acks, bm);
        for (int i = 7; i >= 3; i--) send_bit(d[i]);
        i2c_stop();
        checks++; if (wr_cnt !== base) begin failures++; $display("[TB] FAIL partial_pulses: got %0d expected 0", wr_cnt - base); end
        i2c_start();
        send_byte(8'h73, a);
        recv_byte(1'b0, got);
        i2c_stop();
        checks++; if (got !== m_rf[m_ptr]) begin failures++; $display("[TB] FAIL partial_ptr_read: got %h expected %h", got, m_rf[m_ptr]); end
        m_ptr = m_ptr + 8'd1;
    endtask

    task automatic test_reset_mid();
        int         acks, base;
        logic       bm, a;
        logic [7:0] r, d;
        r = 8'($urandom); d = 8'($urandom);
        base = wr_cnt;
        i2c_start();
        send_byte(8'h72, a);
        send_byte(r, a);
        for (int i = 7; i >= 5; i--) send_bit(d[i]);
        sda_m = d[4]; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (bus.sda_oe_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_sda_oe: got %b expected 0", bus.sda_oe_o); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
        for (int i = 0; i < 256; i++) m_rf[i] = 8'h00;
        m_ptr = 8'h00;
        wait_clk(3);
        sda_m = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(20);
        checks++; if (wr_cnt !== base) begin failures++; $display("[TB] FAIL rstmid_pulses: got %0d expected 0", wr_cnt - base); end
        dbg_addr = 8'h41; wait_clk(2);
        checks++; if (dbg_data !== m_rf[8'h41]) begin failures++; $display("[TB] FAIL rstmid_dbg_cleared: got %h expected %h", dbg_data, m_rf[8'h41]); end
        write_txn(8'h72, r, d, 8'h00, 1, 1'b1, acks, bm);
        checks++; if (acks !== 3) begin failures++; $display("[TB] FAIL rstmid_next_acks: got %0d expected 3", acks); end
        checks++; if (wr_cnt - base !== 1) begin failures++; $display("[TB] FAIL rstmid_next_pulses: got %0d expected 1", wr_cnt - base); end
        checks++; if ({log_addr[base], log_data[base]} !== {r, d}) begin failures++; $display("[TB] FAIL rstmid_next_write: got %h/%h expected %h/%h", log_addr[base], log_data[base], r, d); end
    endtask

    task automatic test_config_sequence();
        logic [7:0] tbl_reg [41];
        logic [7:0] tbl_dat [41];
        int         acks, base;
        logic       bm;
        for (int i = 0; i < 41; i++) begin
            tbl_reg[i] = 8'($urandom);
            tbl_dat[i] = 8'($urandom);
        end
        base = wr_cnt;
        for (int i = 0; i < 41; i++) begin
            write_txn(8'h72, tbl_reg[i], tbl_dat[i], 8'h00, 1, 1'b1, acks, bm);
            checks++; if (acks !== 3) begin failures++; $display("[TB] FAIL config_acks%0d: got %0d expected 3", i, acks); end
        end
        checks++; if (wr_cnt - base !== 41) begin failures++; $display("[TB] FAIL config_pulses: got %0d expected 41", wr_cnt - base); end
        for (int i = 0; i < 41 && base + i < wr_cnt; i++) begin
            checks++;
            if ({log_addr[base+i], log_data[base+i]} !== {tbl_reg[i], tbl_dat[i]}) begin
                failures++;
                $display("[TB] FAIL config_write%0d: got %h/%h expected %h/%h", i, log_addr[base+i], log_data[base+i], tbl_reg[i], tbl_dat[i]);
            end
        end
        for (int i = 0; i < 41; i++) begin
            dbg_addr = tbl_reg[i]; wait_clk(2);
            checks++; if (dbg_data !== m_rf[tbl_reg[i]]) begin failures++; $display("[TB] FAIL config_dbg%0d: addr %h got %h expected %h", i, tbl_reg[i], dbg_data, m_rf[tbl_reg[i]]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_wrong_addr();
        test_burst_wrap();
        test_read();
        test_partial_stop();
        test_reset_mid();
        test_config_sequence();
        checks++; if (wr_long !== 0) begin failures++; $display("[TB] FAIL strobe_width: got %0d long pulses expected 0", wr_long); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
